instruction_fetch_unit: RTL and testbench



---
 rtl/ifetch_pkg.sv | 36 +++
 rtl/ifetch_pc.sv | 43 ++++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the instruction fetch unit:
//            the fetch FSM state encoding, the HALT opcode value and the
//            positions of the opcode/operand fields in an instruction word.
// Ports    : none (package)
// Config   : IFETCH_HALT_EN (consumed by instruction_fetch_unit) makes
//            OP_HALT stop the fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Fetch FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } ifetch_state_t;

    // Opcode that parks the fetch unit when the halt feature is built in.
    localparam logic [3:0] OP_HALT = 4'b1110;

    // The opcode is the top OPC_W bits of the word; the operand is the rest,
    // starting at bit OPND_LSB.
    localparam int OPC_W    = 4;
    localparam int OPND_LSB = 0;

    // Bit index of the opcode LSB for a given instruction width.
    function automatic int opc_lsb(input int instr_w);
        return instr_w - OPC_W;
    endfunction

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pc
// Purpose  : Program counter register. Loads RESET_PC on reset; on each
//            advance strobe loads either branch_target or pc+1 (wrapping
//            modulo 2^ADDR_W).
// Ports    : clk, reset      - clock, synchronous active-high reset
//            advance         - one-cycle strobe: update the PC this edge
//            branch          - take branch_target instead of pc+1 on advance
//            branch_target   - branch destination
//            pc              - current program counter
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;

    // Natural overflow of the ADDR_W-bit add gives the all-ones -> 0 wrap.
    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (advance) begin
            pc_q <= branch ? branch_target : pc_inc;
        end
    end

    assign pc = pc_q;

endmodule : ifetch_pc
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetches instruction words from program memory into an
//            instruction register and hands opcode/operand downstream with a
//            valid/ready handshake. Owns the PC (increment or branch load).
// Ports    : Clk, Reset                 - clock, sync active-high reset
//            MemReq/MemAddr/MemAck/MemData - program memory read port
//            OpCode, Operand, InstrValid  - instruction to the decoder
//            InstrReady                   - decoder consumes on Valid&&Ready
//            Branch, BranchTarget         - PC redirect, used on handshake
//            PC                           - current / pending address
//            Halted                       - HALT state reached
// Config   : `define IFETCH_HALT_EN to make opcode 4'b1110 park the unit in
//            HALT until reset. Without it Halted is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic                 MemReq,
    output logic [ADDR_W-1:0]    MemAddr,
    input  logic                 MemAck,
    input  logic [INSTR_W-1:0]   MemData,
    output logic [OPC_W-1:0]     OpCode,
    output logic [INSTR_W-5:0]   Operand,
    output logic                 InstrValid,
    input  logic                 InstrReady,
    input  logic                 Branch,
    input  logic [ADDR_W-1:0]    BranchTarget,
    output logic [ADDR_W-1:0]    PC,
    output logic                 Halted
);

    localparam int OPC_LSB = opc_lsb(INSTR_W);

    ifetch_state_t        state_q;
    ifetch_state_t        state_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    pc;
    logic                 handshake;
    logic                 halt_hit;
    logic                 advance;
    logic                 load_ir;

    // ------------------------------------------------------------------
    // Handshake / control decode
    // ------------------------------------------------------------------
    assign handshake = (state_q == HOLD) && InstrReady;
    // Ack only counts while a request is actually outstanding.
    assign load_ir   = (state_q == REQ) && MemAck;

`ifdef IFETCH_HALT_EN
    assign halt_hit  = (instr_q[INSTR_W-1:OPC_LSB] == OP_HALT);
`else
    assign halt_hit  = 1'b0;
`endif

    // A consumed HALT leaves the PC pointing at the HALT instruction.
    assign advance   = handshake && !halt_hit;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (MemAck) state_d = HOLD;
            HOLD:    if (handshake) state_d = halt_hit ? HALT : REQ;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        MemReq     = (state_q == REQ);
        InstrValid = (state_q == HOLD);
`ifdef IFETCH_HALT_EN
        Halted     = (state_q == HALT);
`else
        Halted     = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q <= '0;
        end else if (load_ir) begin
            instr_q <= MemData;
        end
    end

    assign OpCode  = instr_q[INSTR_W-1:OPC_LSB];
    assign Operand = instr_q[OPC_LSB-1:OPND_LSB];

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    ifetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (Clk),
        .reset         (Reset),
        .advance       (advance),
        .branch        (Branch),
        .branch_target (BranchTarget),
        .pc            (pc)
    );

    assign MemAddr = pc;
    assign PC      = pc;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed self-checking bench for instruction_fetch_unit
//            (ADDR_W=8, INSTR_W=16, RESET_PC=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemReq;
    logic [7:0]  MemAddr;
    logic        MemAck;
    logic [15:0] MemData;
    logic [3:0]  OpCode;
    logic [11:0] Operand;
    logic        InstrValid;
    logic        InstrReady;
    logic        Branch;
    logic [7:0]  BranchTarget;
    logic [7:0]  PC;
    logic        Halted;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .OpCode       (OpCode),
        .Operand      (Operand),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .Halted       (Halted)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; MemAck = 1'b0; MemData = 16'h0000; InstrReady = 1'b0;
        Branch = 1'b0; BranchTarget = 8'h00;
        tick(); tick();
        checks++; if (MemReq !== 1'b0)    begin errors++; $display("FAIL rst_memreq got %0b exp 0", MemReq); end
        checks++; if (PC !== 8'h00)       begin errors++; $display("FAIL rst_pc got %h exp 00", PC); end
        checks++; if (MemAddr !== 8'h00)  begin errors++; $display("FAIL rst_memaddr got %h exp 00", MemAddr); end
        checks++; if (OpCode !== 4'h0 || Operand !== 12'h000)
                                          begin errors++; $display("FAIL rst_ir got %h/%h exp 0/000", OpCode, Operand); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", InstrValid); end
        checks++; if (Halted !== 1'b0)    begin errors++; $display("FAIL rst_halted got %0b exp 0", Halted); end
    endtask

    // Zero-wait memory, always-ready consumer: REQ/HOLD alternation.
    task automatic test_stream();
        MemAck = 1'b1; InstrReady = 1'b1; MemData = 16'h3ABC;
        Reset = 1'b0;
        // IDLE cycle
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL idle_memreq got %0b exp 0", MemReq); end
        tick(); // REQ, PC 0
        checks++; if (MemReq !== 1'b1 || MemAddr !== 8'h00)
            begin errors++; $display("FAIL first_req got req=%0b addr=%h exp 1/00", MemReq, MemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL first_req_valid got %0b exp 0", InstrValid); end
        tick(); // HOLD
        checks++; if (InstrValid !== 1'b1 || OpCode !== 4'h3 || Operand !== 12'hABC)
            begin errors++; $display("FAIL first_instr got v=%0b %h/%h exp 1 3/ABC", InstrValid, OpCode, Operand); end
        checks++; if (MemReq !== 1'b0 || PC !== 8'h00)
            begin errors++; $display("FAIL hold0 got req=%0b pc=%h exp 0/00", MemReq, PC); end
        tick(); // REQ, PC 1
        checks++; if (MemReq !== 1'b1 || PC !== 8'h01)
            begin errors++; $display("FAIL req1 got req=%0b pc=%h exp 1/01", MemReq, PC); end
        tick(); // HOLD, PC 1
        checks++; if (InstrValid !== 1'b1 || PC !== 8'h01)
            begin errors++; $display("FAIL hold1 got v=%0b pc=%h exp 1/01", InstrValid, PC); end
        tick(); // REQ, PC 2
        checks++; if (MemReq !== 1'b1 || PC !== 8'h02)
            begin errors++; $display("FAIL req2 got req=%0b pc=%h exp 1/02", MemReq, PC); end
    endtask

    // Consumer stalls 5 cycles; a late ack must not overwrite the register.
    task automatic test_stall();
        InstrReady = 1'b0;
        tick(); // HOLD with 3ABC, PC 2
        MemData = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (InstrValid !== 1'b1 || MemReq !== 1'b0 || PC !== 8'h02 ||
                OpCode !== 4'h3 || Operand !== 12'hABC) begin
                errors++;
                $display("FAIL stall[%0d] got v=%0b req=%0b pc=%h %h/%h exp 1/0/02 3/ABC",
                         i, InstrValid, MemReq, PC, OpCode, Operand);
            end
            tick();
        end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL stall_end_valid got %0b exp 1", InstrValid); end
        InstrReady = 1'b1;
        tick(); // handshake -> REQ, PC 3
        checks++; if (MemReq !== 1'b1 || PC !== 8'h03)
            begin errors++; $display("FAIL stall_release got req=%0b pc=%h exp 1/03", MemReq, PC); end
    endtask

    // Branch outside a handshake is ignored; on a handshake it redirects.
    task automatic test_branch();
        InstrReady = 1'b0; Branch = 1'b1; BranchTarget = 8'h77;
        tick(); // HOLD, PC 3
        tick(); // still HOLD
        checks++; if (PC !== 8'h03 || InstrValid !== 1'b1)
            begin errors++; $display("FAIL branch_ignored got pc=%h v=%0b exp 03/1", PC, InstrValid); end
        BranchTarget = 8'h40; InstrReady = 1'b1;
        tick(); // handshake with branch -> REQ at 40
        checks++; if (MemAddr !== 8'h40 || MemReq !== 1'b1)
            begin errors++; $display("FAIL branch_taken got addr=%h req=%0b exp 40/1", MemAddr, MemReq); end
        Branch = 1'b0;
    endtask

    // Branch to FF, then a plain handshake wraps the PC to 00.
    task automatic test_wrap();
        tick(); // HOLD at 40
        Branch = 1'b1; BranchTarget = 8'hFF;
        tick(); // REQ at FF
        Branch = 1'b0;
        checks++; if (PC !== 8'hFF) begin errors++; $display("FAIL wrap_setup got pc=%h exp FF", PC); end
        tick(); // HOLD at FF
        tick(); // REQ at 00
        checks++; if (MemAddr !== 8'h00 || MemReq !== 1'b1)
            begin errors++; $display("FAIL wrap got addr=%h req=%0b exp 00/1", MemAddr, MemReq); end
    endtask

    // Reset while a request waits on ack; the late ack must be dropped.
    task automatic test_reset_mid_req();
        tick(); // HOLD at 00
        tick(); // REQ at 01
        MemAck = 1'b0;
        tick(); // REQ waiting
        checks++; if (MemReq !== 1'b1 || PC !== 8'h01 || InstrValid !== 1'b0)
            begin errors++; $display("FAIL ack_wait got req=%0b pc=%h v=%0b exp 1/01/0", MemReq, PC, InstrValid); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0; MemAck = 1'b1; MemData = 16'h9123;
        checks++; if (MemReq !== 1'b0 || PC !== 8'h00 || InstrValid !== 1'b0 || OpCode !== 4'h0)
            begin errors++; $display("FAIL reset_mid_req got req=%0b pc=%h v=%0b op=%h exp 0/00/0/0", MemReq, PC, InstrValid, OpCode); end
        tick(); // IDLE -> REQ, ack in IDLE ignored
        checks++; if (MemReq !== 1'b1 || MemAddr !== 8'h00 || InstrValid !== 1'b0 || OpCode !== 4'h0)
            begin errors++; $display("FAIL refetch got req=%0b addr=%h v=%0b op=%h exp 1/00/0/0", MemReq, MemAddr, InstrValid, OpCode); end
    endtask

    // Opcode 4'hE: halts with the feature built in, fetched normally otherwise.
    task automatic test_halt();
        MemData = 16'hE000;
        InstrReady = 1'b1;
        tick(); // HOLD with E000
        checks++; if (OpCode !== 4'hE || InstrValid !== 1'b1)
            begin errors++; $display("FAIL halt_fetch got op=%h v=%0b exp E/1", OpCode, InstrValid); end
        tick(); // handshake
`ifdef IFETCH_HALT_EN
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (Halted !== 1'b1 || MemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== 8'h00) begin
                errors++;
                $display("FAIL halt[%0d] got h=%0b req=%0b v=%0b pc=%h exp 1/0/0/00",
                         i, Halted, MemReq, InstrValid, PC);
            end
            tick();
        end
`else
        checks++; if (Halted !== 1'b0 || MemReq !== 1'b1 || PC !== 8'h01)
            begin errors++; $display("FAIL no_halt got h=%0b req=%0b pc=%h exp 0/1/01", Halted, MemReq, PC); end
`endif
        Reset = 1'b1;
        tick();
        checks++; if (Halted !== 1'b0 || PC !== 8'h00 || MemReq !== 1'b0)
            begin errors++; $display("FAIL halt_reset got h=%0b pc=%h req=%0b exp 0/00/0", Halted, PC, MemReq); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid_req();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
